// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART single-byte command decoder with optional TX echo
// Optional feature macro: UART_CMD_ECHO_EN (adds the ECHO state and TX FIFO push path)
module uart_cmd_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_empty,
    input  logic [7:0]           rx_pop_data,
    output logic                 rx_pop,
    input  logic                 tx_full,
    output logic                 tx_push,
    output logic [7:0]           tx_push_data,
    output logic                 cmd_valid,
    output logic [2:0]           cmd_code,
    output logic                 cmd_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ECHO   = 2'd2
    } state_t;

    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    state_t     state;
    state_t     state_nxt;
    logic [7:0] byte_q;
    logic       pop_c;
    logic       push_c;
    logic       dec_hit;
    logic [2:0] dec_code;

    // State register; reset abandons any byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and FIFO strobes; only IDLE may pop, so one byte is in flight at most.
    always_comb begin
        state_nxt = state;
        pop_c     = 1'b0;
        push_c    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_empty) begin
                    pop_c     = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
`ifdef UART_CMD_ECHO_EN
                state_nxt = ECHO;
`else
                state_nxt = IDLE;
`endif
            end
            ECHO: begin
`ifdef UART_CMD_ECHO_EN
                // Hold the byte until the TX FIFO has room; never drop it.
                if (!tx_full) begin
                    push_c    = 1'b1;
                    state_nxt = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are forced low while reset is held, even though the state is already IDLE.
    assign rx_pop = pop_c & ~rst;

`ifdef UART_CMD_ECHO_EN
    assign tx_push      = push_c & ~rst;
    assign tx_push_data = tx_push ? byte_q : 8'h00;
`else
    logic unused_echo;
    assign unused_echo  = tx_full | push_c;
    assign tx_push      = 1'b0;
    assign tx_push_data = 8'h00;
`endif

    // Capture the FIFO head on the pop edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_q <= 8'h00;
        end else if (pop_c) begin
            byte_q <= rx_pop_data;
        end
    end

    // Case-insensitive command letter lookup.
    always_comb begin
        dec_hit  = 1'b1;
        dec_code = 3'd0;
        case (byte_q)
            8'h52, 8'h72: dec_code = 3'd0;
            8'h53, 8'h73: dec_code = 3'd1;
            8'h43, 8'h63: dec_code = 3'd2;
            8'h55, 8'h75: dec_code = 3'd3;
            8'h44, 8'h64: dec_code = 3'd4;
            default: begin
                dec_hit  = 1'b0;
                dec_code = 3'd0;
            end
        endcase
    end

    // Registered decode result: exactly one of cmd_valid/cmd_err pulses per byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_code  <= 3'd0;
            err_cnt   <= '0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            if (state == DECODE) begin
                if (dec_hit) begin
                    cmd_valid <= 1'b1;
                    cmd_code  <= dec_code;
                end else begin
                    cmd_err <= 1'b1;
                    if (err_cnt != ERR_MAX) begin
                        err_cnt <= err_cnt + ERR_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

    localparam int ERR_MAX = 255;
`ifdef UART_CMD_ECHO_EN
    localparam int STRIDE = 3;
`else
    localparam int STRIDE = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_pop_data = 8'h00;
    logic       rx_pop;
    logic       tx_full = 1'b0;
    logic       tx_push;
    logic [7:0] tx_push_data;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_err;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    uart_cmd_decoder #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_pop_data(rx_pop_data),
        .rx_pop(rx_pop), .tx_full(tx_full), .tx_push(tx_push),
        .tx_push_data(tx_push_data), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_err(cmd_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // RX FIFO contents and observation logs
    logic [7:0] fifo[$];
    int         pop_cycles[$];
    int         valid_codes[$];
    int         err_pulses;
    logic [7:0] push_data[$];
    int         push_cycles[$];
    int         valid_cycles[$];
    bit         pop_seen = 0;
    int         cyc = 0;

    // Reference model state
    bit         res_pending = 0;
    int         res_cycle;
    logic [7:0] res_byte;
    bit         echo_pending = 0;
    int         echo_cycle;
    logic [7:0] echo_byte;
    int         next_free = 0;
    int         m_code = 0;
    int         m_err = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)", name, cyc, act, act, exp, exp);
        end
    endtask

    function automatic bit cmd_lookup(input logic [7:0] b, output int code);
        logic [7:0] u;
        u = (b >= "a" && b <= "z") ? b - 8'd32 : b;
        code = 0;
        case (u)
            "R": begin code = 0; return 1; end
            "S": begin code = 1; return 1; end
            "C": begin code = 2; return 1; end
            "U": begin code = 3; return 1; end
            "D": begin code = 4; return 1; end
            default: return 0;
        endcase
    endfunction

    function automatic void refresh();
        rx_empty    = (fifo.size() == 0);
        rx_pop_data = rx_empty ? 8'h00 : fifo[0];
    endfunction

    // FIFO side: retire the popped head shortly after the edge that consumed it.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (pop_seen && fifo.size() != 0) void'(fifo.pop_front());
        pop_seen = 0;
        refresh();
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        bit         e_pop, e_val, e_err, e_push;
        logic [7:0] e_data;
        int         code;
        e_pop = 0; e_val = 0; e_err = 0; e_push = 0; e_data = 8'h00;
        if (rst) begin
            res_pending  = 0;
            echo_pending = 0;
            next_free    = 0;
            m_code       = 0;
            m_err        = 0;
        end else begin
            if (res_pending && cyc == res_cycle) begin
                res_pending = 0;
                if (cmd_lookup(res_byte, code)) begin
                    e_val  = 1;
                    m_code = code;
                end else begin
                    e_err = 1;
                    if (m_err != ERR_MAX) m_err++;
                end
            end
            if (echo_pending && cyc >= echo_cycle && !tx_full) begin
                e_push       = 1;
                e_data       = echo_byte;
                echo_pending = 0;
                next_free    = cyc + 1;
            end
            if (fifo.size() != 0 && cyc >= next_free && !echo_pending) begin
                e_pop       = 1;
                res_pending = 1;
                res_cycle   = cyc + 2;
                res_byte    = fifo[0];
`ifdef UART_CMD_ECHO_EN
                echo_pending = 1;
                echo_cycle   = cyc + 2;
                echo_byte    = fifo[0];
                next_free    = 32'h7fff_ffff;
`else
                next_free    = cyc + 2;
`endif
            end
        end
        check("rx_pop", rx_pop, e_pop);
        check("cmd_valid", cmd_valid, e_val);
        check("cmd_err", cmd_err, e_err);
        check("cmd_code", cmd_code, m_code);
        check("err_cnt", err_cnt, m_err);
        check("tx_push", tx_push, e_push);
        check("tx_push_data", tx_push_data, e_data);
        if (rx_pop) begin
            pop_seen = 1;
            pop_cycles.push_back(cyc);
        end
        if (cmd_valid) begin
            valid_codes.push_back(cmd_code);
            valid_cycles.push_back(cyc);
        end
        if (cmd_err) err_pulses++;
        if (tx_push) begin
            push_data.push_back(tx_push_data);
            push_cycles.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        refresh();
    endtask

    task automatic clear_logs();
        pop_cycles.delete();
        valid_codes.delete();
        valid_cycles.delete();
        push_data.delete();
        push_cycles.delete();
        err_pulses = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((fifo.size() != 0 || res_pending || echo_pending) && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s timeout: still busy after %0d cycles", name, budget);
        end
        step(2);
    endtask

    initial begin
        // Reset, then 20 idle cycles
        step(3);
        rst = 1'b0;
        clear_logs();
        step(20);
        check("idle_pops", pop_cycles.size(), 0);
        check("idle_valids", valid_codes.size() + err_pulses, 0);
        check("idle_pushes", push_data.size(), 0);
        check("idle_err_cnt", err_cnt, 0);

        // Single 'r' and its latency
        clear_logs();
        push_byte(8'h72);
        wait_idle("r_byte", 20);
        check("r_valid_count", valid_codes.size(), 1);
        if (valid_codes.size() == 1 && pop_cycles.size() == 1) begin
            check("r_code", valid_codes[0], 0);
            check("r_latency", valid_cycles[0] - pop_cycles[0], 2);
        end
`ifdef UART_CMD_ECHO_EN
        check("r_push_count", push_data.size(), 1);
        if (push_data.size() == 1 && pop_cycles.size() == 1) begin
            check("r_push_data", push_data[0], 8'h72);
            check("r_push_latency", push_cycles[0] - pop_cycles[0], 2);
        end
`else
        check("r_push_count", push_data.size(), 0);
`endif

        // Back-to-back S c U D
        clear_logs();
        push_byte("S"); push_byte("c"); push_byte("U"); push_byte("D");
        wait_idle("scud", 40);
        check("scud_count", valid_codes.size(), 4);
        for (int i = 0; i < valid_codes.size() && i < 4; i++)
            check("scud_code", valid_codes[i], i + 1);
        for (int i = 1; i < pop_cycles.size(); i++)
            check("scud_pop_stride", pop_cycles[i] - pop_cycles[i-1], STRIDE);

        // Unrecognised byte keeps cmd_code
        clear_logs();
        push_byte(8'h41);
        wait_idle("bad_a", 20);
        check("a_err_pulses", err_pulses, 1);
        check("a_err_cnt", err_cnt, 1);
        check("a_cmd_code", cmd_code, 4);
        check("a_valids", valid_codes.size(), 0);

        // Saturation after 300 more bad bytes
        for (int i = 0; i < 300; i++) push_byte(8'h41);
        wait_idle("bad_300", 1200);
        check("sat_err_cnt", err_cnt, 255);
        check("sat_cmd_code", cmd_code, 4);

        // TX backpressure
        clear_logs();
        tx_full = 1'b1;
        push_byte(8'h72);
        push_byte(8'h73);
        step(12);
`ifdef UART_CMD_ECHO_EN
        check("bp_no_push", push_data.size(), 0);
        check("bp_one_pop", pop_cycles.size(), 1);
        tx_full = 1'b0;
        wait_idle("bp_release", 30);
        check("bp_push_count", push_data.size(), 2);
        if (push_data.size() == 2) begin
            check("bp_push0", push_data[0], 8'h72);
            check("bp_push1", push_data[1], 8'h73);
        end
        if (pop_cycles.size() == 2 && push_cycles.size() == 2)
            check("bp_next_pop", pop_cycles[1] - push_cycles[0], 1);
`else
        check("bp_ignored_pops", pop_cycles.size(), 2);
        check("bp_no_push", push_data.size(), 0);
        tx_full = 1'b0;
        wait_idle("bp_release", 30);
`endif
        check("bp_codes", valid_codes.size(), 2);

        // Reset in the middle of a transaction
        clear_logs();
`ifdef UART_CMD_ECHO_EN
        tx_full = 1'b1;
        push_byte("c");
        step(2);
`else
        push_byte("c");
        step(1);
`endif
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        tx_full = 1'b0;
        step(4);
        check("rst_no_push", push_data.size(), 0);
`ifndef UART_CMD_ECHO_EN
        check("rst_no_valid", valid_codes.size(), 0);
`endif
        check("rst_err_cnt", err_cnt, 0);
        check("rst_cmd_code", cmd_code, 0);
        clear_logs();
        push_byte("d");
        wait_idle("post_rst", 20);
        check("post_rst_count", valid_codes.size(), 1);
        check("post_rst_code", cmd_code, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 The block SHALL have one parameter: ERR_CNT_W, default 8, width of the saturating error counter.
REQ-002 The block SHALL have these ports:
- clk  input  1  system clock; all state on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_empty  input  1  RX FIFO empty flag.
- rx_pop_data  input  8  RX FIFO head byte; valid whenever rx_empty=0.
- rx_pop  output  1  one-cycle pop strobe to the RX FIFO.
- tx_full  input  1  TX FIFO full flag.
- tx_push  output  1  one-cycle push strobe to the TX FIFO.
- tx_push_data  output  8  byte for the TX FIFO.
- cmd_valid  output  1  one-cycle pulse: cmd_code is valid.
- cmd_code  output  3  decoded command, held until the next cmd_valid.
- cmd_err  output  1  one-cycle pulse: unrecognised byte.
- err_cnt  output  ERR_CNT_W  count of unrecognised bytes.

Function
REQ-003 The FSM SHALL have three states: IDLE, DECODE and ECHO.
REQ-004 In IDLE with rx_empty=0, the block SHALL assert rx_pop (combinational from state and rx_empty) for exactly one cycle, capture rx_pop_data into an internal byte register on that edge, and go to DECODE.
REQ-005 In IDLE with rx_empty=1, the block SHALL stay in IDLE with rx_pop=0.
REQ-006 In DECODE, the block SHALL decode the captured byte case-insensitively:
- 'R'/'r' (0x52/0x72) -> 0 (run)
- 'S'/'s' -> 1 (stop)
- 'C'/'c' -> 2 (clear)
- 'U'/'u' -> 3 (up)
- 'D'/'d' -> 4 (down)
REQ-007 For a recognised byte, the block SHALL drive cmd_valid=1 and cmd_code=the code, both registered, in the cycle after DECODE (one cycle after the pop edge + 1).
REQ-008 For any other byte, the block SHALL pulse cmd_err for one cycle with the same timing as cmd_valid, SHALL leave cmd_code unchanged, and SHALL increment err_cnt by 1.
REQ-009 err_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-010 cmd_valid and cmd_err SHALL never both be 1 in the same cycle.
REQ-011 After DECODE, the next state SHALL be ECHO when echo is compiled in, otherwise IDLE.
REQ-012 In ECHO with tx_full=0, the block SHALL assert tx_push for one cycle with tx_push_data=captured byte and return to IDLE.
REQ-013 In ECHO with tx_full=1, the block SHALL stay in ECHO with tx_push=0 and SHALL NOT pop the RX FIFO; the byte SHALL NOT be dropped.
REQ-014 tx_push_data SHALL hold the captured byte whenever tx_push=1 and SHALL be 0 otherwise.
REQ-015 rx_pop SHALL never be asserted outside IDLE, so at most one byte is in flight.
REQ-016 Throughput SHALL be one byte per 2 cycles without echo, and one byte per 3 cycles with echo and tx_full=0.

Reset
REQ-017 On rst=1, asynchronously: state SHALL be IDLE; the byte register, cmd_code and err_cnt SHALL be 0; cmd_valid, cmd_err and tx_push_data SHALL be 0.
REQ-018 rx_pop and tx_push SHALL be 0 throughout reset.
REQ-019 A reset asserted mid-DECODE or mid-ECHO SHALL abandon the byte with no pulse or push, and the block SHALL resume from IDLE after release.

Configuration
REQ-020 With macro UART_CMD_ECHO_EN defined, the ECHO state and the TX FIFO push path SHALL be present as in REQ-012..014.
REQ-021 Without UART_CMD_ECHO_EN, DECODE SHALL return to IDLE, tx_push and tx_push_data SHALL be tied to 0, tx_full SHALL be ignored, and ECHO SHALL be unreachable.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset then idle, rx_empty=1 for 20 cycles -> rx_pop, cmd_valid, cmd_err, tx_push all 0; err_cnt=0.
- FIFO holds 0x72 ('r') -> rx_pop at cycle N, cmd_valid at N+2 with cmd_code=0; with ECHO_EN, tx_push with 0x72 at N+2.
- Bytes 'S','c','U','D' back-to-back -> cmd_code sequence 1,2,3,4, one cmd_valid each; no echo: pops every 2 cycles.
- Byte 0x41 ('A') -> cmd_err pulse, err_cnt=1, cmd_code keeps its previous value; 300 bad bytes with ERR_CNT_W=8 -> err_cnt=255.
- ECHO_EN, tx_full=1 for 10 cycles after 'r' -> no tx_push and no further rx_pop; tx_full drops -> single tx_push of 0x72, then the next pop.
- rst pulsed while in ECHO -> no tx_push; state IDLE, err_cnt=0; the next byte decodes normally.
